lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/neuron_pkg.sv | 17 +
 rtl/post_delay_ctr.sv | 36 +++
 rtl/lif_neuron.sv | 149 ++++++++++++++
 tb/tb_lif_neuron.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared types and constants for the leaky integrate-and-fire neuron slice.
//   neuronState_t   : neuron operating phase {INTEG, FIRE, REFRAC}
//   POST_DELAY_W    : width of the post-spike tWin delay counter
//   POST_DELAY_MAX  : saturation value of that counter (also its reset value)
package neuron_pkg;

   typedef enum logic [1:0] {
      INTEG  = 2'd0,
      FIRE   = 2'd1,
      REFRAC = 2'd2
   } neuronState_t;

   localparam int                POST_DELAY_W   = 4;
   localparam logic [POST_DELAY_W-1:0] POST_DELAY_MAX = 4'd15;

endpackage : neuron_pkg

// File: rtl/post_delay_ctr.sv
// post_delay_ctr
// Saturating count of tWin ticks since the last output spike.
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous active-low reset, forces count to POST_DELAY_MAX
//   clear  in  : zero the count (takes priority over tick)
//   tick   in  : one-cycle timing-window tick, increments the count
//   count  out : registered count, saturates at POST_DELAY_MAX
module post_delay_ctr
   import neuron_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    tick,
   output logic [POST_DELAY_W-1:0] count
);

   logic [POST_DELAY_W-1:0] count_r;

   // Count register: clear beats tick so a tick coinciding with a spike still reads 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= POST_DELAY_MAX;
      end else if (clear) begin
         count_r <= '0;
      end else if (tick && (count_r != POST_DELAY_MAX)) begin
         count_r <= count_r + 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule : post_delay_ctr

// File: rtl/lif_neuron.sv
// lif_neuron
// Leaky integrate-and-fire neuron. Integrates weighted synaptic current into a
// saturating membrane potential, emits a one-cycle spike when the threshold is
// reached, then holds a fixed refractory period during which input is ignored.
// Build option: define LIF_NEURON_LEAK_EN to enable the membrane leak
// (mem >> LEAK_SHIFT per cycle); without it the neuron is pure integrate-and-fire.
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous active-low reset
//   synIn      in  : unsigned weighted synaptic current [WIDTH]
//   synValid   in  : integrate synIn this cycle
//   tWin       in  : one-cycle timing-window tick
//   postSpike  out : registered one-cycle spike (high only in FIRE)
//   postDelay  out : saturating tWin ticks since the last spike [4]
//   membrane   out : registered membrane potential [WIDTH]
module lif_neuron
   import neuron_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int THRESH     = 100,
   parameter int LEAK_SHIFT = 4,
   parameter int REFRAC_CYC = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        synIn,
   input  logic                    synValid,
   input  logic                    tWin,
   output logic                    postSpike,
   output logic [POST_DELAY_W-1:0] postDelay,
   output logic [WIDTH-1:0]        membrane
);

`ifdef LIF_NEURON_LEAK_EN
   localparam bit LEAK_ON = 1'b1;
`else
   localparam bit LEAK_ON = 1'b0;
`endif

   localparam logic [WIDTH-1:0] THRESH_V    = WIDTH'(THRESH);
   localparam logic [3:0]       REFRAC_LOAD = 4'(REFRAC_CYC - 1);

   neuronState_t     state_r,     stateNext_s;
   logic [WIDTH-1:0] mem_r,       memNext_s;
   logic             postSpike_r, spikeNext_s;
   logic [3:0]       refCnt_r,    refNext_s;
   logic             clearDelay_s;

   logic [WIDTH-1:0] leak_s;
   logic [WIDTH-1:0] drained_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] integ_s;
   logic             crossed_s;

   // Integration datapath: leak never exceeds mem, so only the add can overflow.
   always_comb begin
      leak_s    = '0;
      drained_s = '0;
      sum_s     = '0;
      integ_s   = '0;
      crossed_s = 1'b0;
      if (LEAK_ON) begin
         leak_s = mem_r >> LEAK_SHIFT;
      end else begin
         leak_s = '0;
      end
      drained_s = mem_r - leak_s;
      if (synValid) begin
         sum_s = {1'b0, drained_s} + {1'b0, synIn};
      end else begin
         sum_s = {1'b0, drained_s};
      end
      if (sum_s[WIDTH]) begin
         integ_s = '1;
      end else begin
         integ_s = sum_s[WIDTH-1:0];
      end
      crossed_s = (integ_s >= THRESH_V);
   end

   // Next-state and next-register values for the neuron phase machine.
   always_comb begin
      stateNext_s  = state_r;
      memNext_s    = mem_r;
      spikeNext_s  = 1'b0;
      refNext_s    = refCnt_r;
      clearDelay_s = 1'b0;
      case (state_r)
         INTEG: begin
            if (crossed_s) begin
               stateNext_s  = FIRE;
               memNext_s    = '0;
               spikeNext_s  = 1'b1;
               clearDelay_s = 1'b1;
            end else begin
               memNext_s = integ_s;
            end
         end
         FIRE: begin
            // Keep the delay cleared through the whole spike cycle.
            stateNext_s  = REFRAC;
            memNext_s    = '0;
            refNext_s    = REFRAC_LOAD;
            clearDelay_s = 1'b1;
         end
         REFRAC: begin
            memNext_s = '0;
            if (refCnt_r == 4'd0) begin
               stateNext_s = INTEG;
            end else begin
               refNext_s = refCnt_r - 4'd1;
            end
         end
         default: begin
            stateNext_s = INTEG;
            memNext_s   = '0;
            refNext_s   = 4'd0;
         end
      endcase
   end

   // Phase, membrane, spike and refractory registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= INTEG;
         mem_r       <= '0;
         postSpike_r <= 1'b0;
         refCnt_r    <= 4'd0;
      end else begin
         state_r     <= stateNext_s;
         mem_r       <= memNext_s;
         postSpike_r <= spikeNext_s;
         refCnt_r    <= refNext_s;
      end
   end

   post_delay_ctr u_postDelay (
      .clk   (clk),
      .reset (reset),
      .clear (clearDelay_s),
      .tick  (tWin),
      .count (postDelay)
   );

   assign postSpike = postSpike_r;
   assign membrane  = mem_r;

endmodule : lif_neuron

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron
// Directed and randomized checks of lif_neuron against a behavioural model
// that tracks membrane value, pending spike and remaining refractory cycles.
module tb_lif_neuron;

   localparam int W      = 16;
   localparam int THR    = 100;
   localparam int REFRAC = 4;
   localparam int MAXV   = 65535;

   logic          clk;
   logic          reset;
   logic [W-1:0]  synIn;
   logic          synValid;
   logic          tWin;
   logic          postSpike;
   logic [3:0]    postDelay;
   logic [W-1:0]  membrane;

   int total;
   int bad;

   // behavioural model state
   int mMem;
   int mSpike;
   int mRefLeft;
   int mPd;

   lif_neuron #(
      .WIDTH      (W),
      .THRESH     (THR),
      .LEAK_SHIFT (4),
      .REFRAC_CYC (REFRAC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .synIn     (synIn),
      .synValid  (synValid),
      .tWin      (tWin),
      .postSpike (postSpike),
      .postDelay (postDelay),
      .membrane  (membrane)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int leakOf(input int m);
`ifdef LIF_NEURON_LEAK_EN
      return m / 16;
`else
      return 0;
`endif
   endfunction

   task automatic modelReset();
      mMem     = 0;
      mSpike   = 0;
      mRefLeft = 0;
      mPd      = 15;
   endtask

   // One clock of neuron behaviour, described by phase rules rather than registers.
   task automatic modelStep(input int s, input int v, input int t);
      int nxt;
      int clr;
      clr = 0;
      if (mSpike != 0) begin
         mSpike   = 0;
         mMem     = 0;
         mRefLeft = REFRAC;
         clr      = 1;
      end else if (mRefLeft > 0) begin
         mRefLeft = mRefLeft - 1;
         mMem     = 0;
      end else begin
         nxt = mMem - leakOf(mMem) + ((v != 0) ? s : 0);
         if (nxt > MAXV) nxt = MAXV;
         if (nxt >= THR) begin
            mSpike = 1;
            mMem   = 0;
            clr    = 1;
         end else begin
            mMem = nxt;
         end
      end
      if (clr != 0) mPd = 0;
      else if (t != 0) mPd = (mPd < 15) ? mPd + 1 : 15;
   endtask

   task automatic cycle(input logic [W-1:0] s, input logic v, input logic t);
      synIn    = s;
      synValid = v;
      tWin     = t;
      @(posedge clk);
      modelStep(int'(s), int'(v), int'(t));
      #1;
      check("model_membrane", 32'(membrane), 32'(mMem));
      check("model_spike", 32'(postSpike), 32'(mSpike));
      check("model_postDelay", 32'(postDelay), 32'(mPd));
   endtask

   task automatic doReset();
      reset = 1'b0;
      #2;
      modelReset();
      reset = 1'b1;
   endtask

   initial begin
      int expect2;
      logic [W-1:0] rs;
      total    = 0;
      bad      = 0;
      reset    = 1'b0;
      synIn    = '0;
      synValid = 1'b0;
      tWin     = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_membrane", 32'(membrane), 32'd0);
      check("reset_spike", 32'(postSpike), 32'd0);
      check("reset_postDelay", 32'(postDelay), 32'd15);
      reset = 1'b1;

      // three pulses of 40: 40, 80/78, then spike
`ifdef LIF_NEURON_LEAK_EN
      expect2 = 78;
`else
      expect2 = 80;
`endif
      cycle(16'd40, 1'b1, 1'b0);
      check("seq_mem1", 32'(membrane), 32'd40);
      cycle(16'd40, 1'b1, 1'b0);
      check("seq_mem2", 32'(membrane), 32'(expect2));
      cycle(16'd40, 1'b1, 1'b0);
      check("seq_spike", 32'(postSpike), 32'd1);
      check("seq_mem_fire", 32'(membrane), 32'd0);

      // input ignored through FIRE exit and the refractory period
      for (int i = 0; i < REFRAC + 1; i++) begin
         cycle(16'd200, 1'b1, 1'b0);
         check("refrac_mem", 32'(membrane), 32'd0);
         check("refrac_spike", 32'(postSpike), 32'd0);
      end
      cycle(16'd200, 1'b1, 1'b0);
      check("refrac_first_integ_spike", 32'(postSpike), 32'd1);

      // quiet until integrating again, then 20 ticks saturate postDelay
      for (int i = 0; i < REFRAC + 1; i++) cycle(16'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(16'd0, 1'b0, 1'b1);
      check("pd_saturate", 32'(postDelay), 32'd15);
      cycle(16'd120, 1'b1, 1'b1);
      check("pd_clear_wins_spike", 32'(postSpike), 32'd1);
      check("pd_clear_wins", 32'(postDelay), 32'd0);
      cycle(16'd0, 1'b0, 1'b1);
      check("pd_fire_tick", 32'(postDelay), 32'd0);

      // leak pattern: 40, 40 then leak-only steps
      doReset();
      cycle(16'd40, 1'b1, 1'b0);
      cycle(16'd40, 1'b1, 1'b0);
      check("leak_mem2", 32'(membrane), 32'(expect2));
      cycle(16'd0, 1'b1, 1'b0);
`ifdef LIF_NEURON_LEAK_EN
      check("leak_mem3", 32'(membrane), 32'd74);
`else
      check("leak_mem3", 32'(membrane), 32'd80);
`endif
      cycle(16'd0, 1'b0, 1'b0);
`ifdef LIF_NEURON_LEAK_EN
      check("leak_mem4", 32'(membrane), 32'd70);
`else
      check("leak_mem4", 32'(membrane), 32'd80);
`endif

      // saturation: a wrapping add would land below threshold
      doReset();
      cycle(16'd50, 1'b1, 1'b0);
      check("sat_mem", 32'(membrane), 32'd50);
      cycle(16'hFFFF, 1'b1, 1'b0);
      check("sat_spike", 32'(postSpike), 32'd1);

      // reset asserted while refractory
      cycle(16'd0, 1'b0, 1'b1);
      cycle(16'd0, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      modelReset();
      check("rst_refrac_mem", 32'(membrane), 32'd0);
      check("rst_refrac_spike", 32'(postSpike), 32'd0);
      check("rst_refrac_pd", 32'(postDelay), 32'd15);
      @(posedge clk);
      #2;
      reset = 1'b1;
      cycle(16'd40, 1'b1, 1'b0);
      check("rst_release_integ", 32'(membrane), 32'd40);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) rs = 16'($urandom_range(0, 65535));
         else rs = 16'($urandom_range(0, 45));
         cycle(rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lif_neuron
